// File: rtl/uart_tx.sv
// uart_tx: UART serialiser with 1 start bit, N_DATA data bits (LSB first)
// and an SB_TICK-long stop period, timed by a 16x oversampling s_tick.
// tx_done is a level handshake held until tx_start is seen low.
module uart_tx #(
    parameter int unsigned N_DATA  = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tick,
    input  logic              tx_start,
    input  logic [N_DATA-1:0] tx_dato_in,
    output logic              tx_done,
    output logic              tx_busy,
    output logic              tx
);

    localparam int unsigned TICK_W   = 5;
    localparam int unsigned BIT_W    = 3;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned BIT_LAST = 15;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [N_DATA-1:0]   shift_q, shift_d;
    logic                tx_d, done_d, busy_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            tx_done <= done_d;
            tx_busy <= busy_d;
        end
    end

    // Next state and datapath; counters only move on s_tick
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_dato_in;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(BIT_LAST)) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(BIT_LAST)) begin
                        tick_d  = '0;
                        shift_d = {1'b0, shift_q[N_DATA-1:1]};
                        if (bit_q == BIT_W'(N_DATA - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(SB_TICK - 1)) begin
                        tick_d  = '0;
                        state_d = DONE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DONE: begin
                if (!tx_start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs register with it
    always_comb begin
        tx_d   = 1'b1;
        done_d = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            STOP: begin
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance (8N, 1 stop) and a
// 7-bit / 2-stop instance, s_tick every 4 clk.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic       tx_start_a, tx_start_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       done_a, busy_a, tx_a;
    logic       done_b, busy_b, tx_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tick_cnt = 0;
    bit tick_en  = 1'b0;

    uart_tx #(.N_DATA(8), .SB_TICK(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start_a),
        .tx_dato_in(data_a), .tx_done(done_a), .tx_busy(busy_a), .tx(tx_a)
    );

    uart_tx #(.N_DATA(7), .SB_TICK(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start_b),
        .tx_dato_in(data_b), .tx_done(done_b), .tx_busy(busy_b), .tx(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, s_tick updated
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
        s_tick   = tick_en && (tick_cnt == 0);
    endtask

    function automatic logic cur_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) tx_start_b = v;
        else     tx_start_a = v;
    endtask

    // Send one frame aligned so the acceptance edge also carries an s_tick;
    // tx_start stays high on return (tx_done is up).
    task automatic send(input bit sel, input logic [7:0] data, input int nbits,
                        input int sb, input bit corrupt);
        int c0;
        int guard;
        for (int k = 0; k < 8 && !s_tick; k++) step();
        if (sel) data_b = data[6:0];
        else     data_a = data;
        set_start(sel, 1'b1);
        step();
        c0 = cyc;
        check("accept_tx", 32'(cur_tx(sel)), 32'd0);
        check("accept_busy", 32'(cur_busy(sel)), 32'd1);
        if (corrupt) begin
            data_a = 8'hFF;
            data_b = 7'h7F;
        end
        repeat (32) step();
        check("start_bit", 32'(cur_tx(sel)), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            repeat (64) step();
            check($sformatf("data_bit%0d", i), 32'(cur_tx(sel)), 32'(data[i]));
        end
        repeat (64) step();
        check("stop_bit", 32'(cur_tx(sel)), 32'd1);
        check("no_early_done", 32'(cur_done(sel)), 32'd0);
        guard = 0;
        while (!cur_done(sel) && guard < 2000) begin
            step();
            guard++;
        end
        check("frame_len_clk", 32'(cyc - c0), 32'(4 * (16 * (1 + nbits) + sb)));
        check("done_busy", 32'(cur_busy(sel)), 32'd0);
        check("done_tx", 32'(cur_tx(sel)), 32'd1);
    endtask

    // Drop the request and confirm tx_done falls on the next edge
    task automatic release_req(input bit sel);
        set_start(sel, 1'b0);
        step();
        check("done_fall", 32'(cur_done(sel)), 32'd0);
        check("idle_tx", 32'(cur_tx(sel)), 32'd1);
    endtask

    initial begin
        bit bad_tx, bad_done, bad_busy, held_bad, seen_done;
        rst_n      = 1'b0;
        s_tick     = 1'b0;
        tx_start_a = 1'b0;
        tx_start_b = 1'b0;
        data_a     = 8'h00;
        data_b     = 7'h00;

        // Reset and idle
        repeat (5) step();
        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n   = 1'b1;
        tick_en = 1'b1;
        bad_tx = 0; bad_done = 0; bad_busy = 0;
        repeat (1000) begin
            step();
            if (tx_a !== 1'b1 || tx_b !== 1'b1) bad_tx = 1;
            if (done_a !== 1'b0 || done_b !== 1'b0) bad_done = 1;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) bad_busy = 1;
        end
        check("idle_tx_1000", 32'(bad_tx), 32'd0);
        check("idle_done_1000", 32'(bad_done), 32'd0);
        check("idle_busy_1000", 32'(bad_busy), 32'd0);

        // Single frame 'p', then request held 50 cycles past tx_done
        send(1'b0, 8'h70, 8, 16, 1'b0);
        held_bad = 0;
        repeat (50) begin
            step();
            if (done_a !== 1'b1 || tx_a !== 1'b1 || busy_a !== 1'b0) held_bad = 1;
        end
        check("held_request", 32'(held_bad), 32'd0);
        release_req(1'b0);

        // Data changed right after acceptance must not reach the line
        send(1'b0, 8'h30, 8, 16, 1'b1);
        release_req(1'b0);

        // Mid-frame reset in data bit 3 (a 0 bit of 0x70)
        for (int k = 0; k < 8 && !s_tick; k++) step();
        data_a     = 8'h70;
        tx_start_a = 1'b1;
        step();
        repeat (32 + 64 * 4) step();
        check("pre_reset_bit3", 32'(tx_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_a), 32'd1);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        tx_start_a = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
        seen_done = 0;
        repeat (700) begin
            step();
            if (done_a !== 1'b0 || tx_a !== 1'b1) seen_done = 1;
        end
        check("post_rst_quiet", 32'(seen_done), 32'd0);
        send(1'b0, 8'h61, 8, 16, 1'b0);
        release_req(1'b0);

        // Back-to-back: new request right after tx_done falls
        send(1'b0, 8'hA5, 8, 16, 1'b0);
        release_req(1'b0);

        // 7 data bits, 2 stop bits
        send(1'b1, 8'h55, 7, 32, 1'b0);
        release_req(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that sits directly downstream of the debug unit. It accepts a parallel byte on `tx_dato_in` when `tx_start` is asserted. It serialises the byte as 1 start bit, N_DATA data bits (LSB first) and a stop period, timed by a 16x-oversampling baud tick. Completion is reported on `tx_done` using a level handshake, so a requester that holds `tx_start` high until it sees `tx_done` cannot retrigger a frame.

## Interface
- `N_DATA`, default 8: data bits per frame. Legal values 5..8.
- `SB_TICK`, default 16: stop-period length in s_tick pulses. Legal values 16, 24 or 32 (1, 1.5 or 2 stop bits).
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `s_tick`  in  1: baud-generator strobe, one `clk` wide, 16 per bit time.
- `tx_start`  in  1: transmit request, level-sensitive.
- `tx_dato_in`  in  N_DATA: byte to send. Sampled only when the request is accepted.
- `tx_done`  out  1: frame complete. Held high until `tx_start` is seen low.
- `tx_busy`  out  1: high from acceptance until `tx_done` rises.
- `tx`  out  1: serial line. Idle level is 1.

## Operation
- Reset values: state IDLE, `tx`=1, `tx_done`=0, `tx_busy`=0, tick counter=0, bit counter=0, shift register=0. All outputs are registered.
- State machine: IDLE -> START -> DATA -> STOP -> DONE -> IDLE.
- IDLE:
  - `tx`=1.
  - If `tx_start`=1: load shift register from `tx_dato_in`, clear tick counter, set `tx_busy`=1, go to START.
- START:
  - `tx`=0.
  - Tick counter (5 bits) increments on each `s_tick`.
  - On `s_tick` with count=15: clear count, clear bit counter, go to DATA.
- DATA:
  - `tx`=shift[0].
  - On `s_tick` with count=15: shift right by one and clear count.
  - If bit counter = N_DATA-1, go to STOP; otherwise increment bit counter.
- STOP:
  - `tx`=1.
  - On `s_tick` with count=SB_TICK-1: go to DONE, set `tx_done`=1, `tx_busy`=0.
- DONE:
  - `tx`=1, `tx_done`=1.
  - When `tx_start`=0 is sampled: `tx_done`=0, go to IDLE.
  - While `tx_start` stays high, remain in DONE. No new frame starts.
- Any undefined state encoding returns to IDLE with `tx`=1.
- Changes on `tx_start` or `tx_dato_in` during START/DATA/STOP are ignored.
- Clock cycles without `s_tick` leave all counters unchanged.
- Reset asserted mid-frame aborts the frame at once: `tx`=1, all outputs return to reset values, and no `tx_done` is produced.

## Timing
- Acceptance latency: `tx` falls on the first `clk` edge that samples `tx_start`=1 in IDLE.
- Each bit lasts exactly 16 `s_tick`. The stop period lasts SB_TICK `s_tick`.
- Frame length from `tx` falling to `tx_done` rising is (1+N_DATA)*16 + SB_TICK ticks. With defaults this is 160 ticks.
- `tx_done` rises on the same edge the final stop tick is consumed.
- `tx_done` falls one edge after `tx_start` is sampled low.
- Back-to-back frames: after `tx_done` falls, a new `tx_start` is accepted no earlier than the next edge. `tx` stays 1 for at least one `clk` between frames.
- `s_tick` arriving on the same edge as acceptance is not counted. Counting begins in START.
- An `s_tick` seen in DONE or IDLE has no effect.

## Test plan
- Reset/idle: hold `rst_n`=0 for 5 cycles, then release with no request -> `tx`=1, `tx_done`=0 and `tx_busy`=0 throughout 1000 cycles.
- Single frame: `s_tick` every 4 clk, `tx_dato_in`=0x70 ('p'), pulse `tx_start`, then hold it until `tx_done` -> `tx` reads 0 | 0,0,0,0,1,1,1,0 | 1, each bit 64 clk. `tx_done` rises 640 clk after `tx` falls.
- Held request: keep `tx_start`=1 for 50 cycles after `tx_done` -> `tx_done` stays 1, `tx` stays 1, no second start bit. `tx_done` falls one edge after `tx_start` drops.
- Data stability: send 0x30 ('0') and change `tx_dato_in` to 0xFF on the cycle after acceptance -> line carries 0x30 (bits 0,0,0,0,1,1,0,0).
- Mid-frame reset: assert `rst_n`=0 during DATA bit 3 -> `tx`=1 in the same cycle, no `tx_done`. After release, a new 0x61 frame transmits correctly.
- Parameters: N_DATA=7, SB_TICK=32, data 0x55 -> 7 data bits 1,0,1,0,1,0,1, then `tx`=1 for 32 ticks. Frame length is 160 ticks.
